router_reg_gen: RTL and testbench
=================================

ROUTER_REG_GEN -- requirements
Module: router_reg_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width of data path.
REQ-002 SHALL have parameter HOLD_DEPTH, default 4 (power of 2, >=2), entries in the full-state hold buffer.
REQ-003 SHALL have parameter PAR_MODE, default 0, check mode: 0 = XOR parity, 1 = additive checksum mod 2^DATA_W.
REQ-004 SHALL use one clock; reset is asynchronous and active-high: port clock input 1 (rising-edge clock), port reset input 1 (async active-high reset).
REQ-005 pkt_valid  input  1  packet byte valid from source.
REQ-006 fifo_full  input  1  destination FIFO full.
REQ-007 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  input  1 each  FSM state strobes.
REQ-008 data_in  input  DATA_W  incoming byte.
REQ-009 dout  output  DATA_W  byte to FIFO; dout_valid  output  1  dout loaded this cycle.
REQ-010 parity_done, low_pkt_valid, err, hold_ovf  output  1 each; hold_count  output  $clog2(HOLD_DEPTH)+1  buffer occupancy.

Function
REQ-011 Header register SHALL load data_in when detect_add && pkt_valid.
REQ-012 Accept = ld_state && !full_state; accepted byte goes to dout if !fifo_full && hold_count==0, else is pushed to hold buffer.
REQ-013 Hold buffer SHALL be circular, pointers wrapping mod HOLD_DEPTH; pop when laf_state && !fifo_full && hold_count!=0.
REQ-014 Simultaneous push and pop SHALL leave hold_count unchanged, preserve FIFO order.
REQ-015 Push when hold_count==HOLD_DEPTH SHALL drop the byte and set sticky hold_ovf; hold_ovf clears on detect_add.
REQ-016 dout priority per cycle: lfd_state -> header; else pop -> buffer head; else direct accept -> data_in; else hold value; dout_valid=1 exactly on a load, 1-cycle latency.
REQ-017 Running check SHALL clear on detect_add, fold header on lfd_state, fold each accepted byte with pkt_valid=1 (XOR or add per PAR_MODE, truncated to DATA_W).
REQ-018 Accepted byte with pkt_valid=0 SHALL be captured as packet check byte, not folded; low_pkt_valid sets that cycle.
REQ-019 low_pkt_valid SHALL clear on rst_int_reg; set wins if both same cycle.
REQ-020 parity_done SHALL set the first cycle check byte is captured and hold_count==0; clears on detect_add (clear wins).
REQ-021 err SHALL be registered: 1 on each cycle following parity_done=1 with running check != check byte, else 0.
REQ-022 detect_add mid-packet SHALL flush hold buffer (count 0) and abandon the packet.

Reset
REQ-023 reset SHALL asynchronously zero dout, dout_valid, parity_done, low_pkt_valid, err, hold_ovf, hold_count, pointers, header, check registers.
REQ-024 First post-reset edge SHALL behave as a normal cycle; no state retained across reset.

Configuration
REQ-025 Macro ROUTER_REG_ERRCNT_EN defined: output err_count (16 bits) SHALL increment, saturating at 0xFFFF, on each err rising edge and each hold_ovf rising edge (both same cycle: +2), zeroed by reset.
REQ-026 Macro undefined: err_count port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-027 Shared package router_pkg SHALL hold PAR_XOR/PAR_SUM mode constants and check-fold function.
REQ-028 Hold buffer SHALL be sub-module router_hold_fifo (params DATA_W, HOLD_DEPTH; push/pop/count).

Verification (DATA_W=8, HOLD_DEPTH=4)
REQ-029 PAR_MODE=0, header 0x05, payload 0x11,0x22, check 0x36, fifo_full=0 -> dout 05,11,22,36 sequence, parity_done=1, err stays 0.
REQ-030 Same packet, check 0x37 -> err=1 on cycle after parity_done.
REQ-031 PAR_MODE=1, header 0x05, payload 0x11,0x22, check 0x38 -> err=0; check 0x36 -> err=1.
REQ-032 fifo_full=1 during 3 payload bytes, then laf_state with fifo_full=0 -> hold_count 3 then 2,1,0, bytes emerge in order, parity_done only after drain.
REQ-033 6 bytes pushed while full -> hold_count=4, hold_ovf=1, bytes 5-6 dropped; next detect_add clears hold_ovf and count; with ROUTER_REG_ERRCNT_EN err_count=1.
REQ-034 reset pulsed mid-packet with hold_count=2 -> all outputs 0 immediately, before next clock edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared check-mode constants, dout source selector and check-fold helper
// for the router register block.
package router_pkg;

  localparam int PAR_XOR = 0;
  localparam int PAR_SUM = 1;
  localparam int FOLD_W  = 64;

  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_HDR  = 2'd1,
    SRC_POP  = 2'd2,
    SRC_DIN  = 2'd3
  } dout_src_e;

  // Callers zero-extend to FOLD_W and truncate the result to their byte width.
  function automatic logic [FOLD_W-1:0] chk_fold(input logic [FOLD_W-1:0] acc,
                                                 input logic [FOLD_W-1:0] b,
                                                 input int mode);
    return (mode == PAR_SUM) ? (acc + b) : (acc ^ b);
  endfunction

endpackage

// File: rtl/router_hold_fifo.sv
// Circular hold buffer: head visible combinationally, push/pop take effect on the edge.
// Pushes while full are ignored (caller flags the drop); flush empties it in one cycle.
module router_hold_fifo #(
  parameter int DATA_W     = 8,
  parameter int HOLD_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [DATA_W-1:0]             i_dat,
  output logic [DATA_W-1:0]             o_dat,
  output logic [$clog2(HOLD_DEPTH):0]   o_count,
  output logic                          o_full
);

  localparam int AW = $clog2(HOLD_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [HOLD_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_count == CW'(HOLD_DEPTH));
  assign w_wr    = i_push && !o_full && !i_flush;
  assign w_rd    = i_pop && (r_count != '0) && !i_flush;
  assign o_dat   = r_mem[r_rptr];
  assign o_count = r_count;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr] <= i_dat;
  end

endmodule

// File: rtl/router_reg_gen.sv
// Router register block: header/check registers, hold buffer, dout with 1-cycle latency;
// bytes park in the hold buffer while fifo_full. Optional err_count under ROUTER_REG_ERRCNT_EN.
module router_reg_gen
  import router_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int HOLD_DEPTH = 4,
  parameter int PAR_MODE   = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pkt_valid,
  input  logic                        fifo_full,
  input  logic                        detect_add,
  input  logic                        lfd_state,
  input  logic                        ld_state,
  input  logic                        laf_state,
  input  logic                        full_state,
  input  logic                        rst_int_reg,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           dout,
  output logic                        dout_valid,
  output logic                        parity_done,
  output logic                        low_pkt_valid,
  output logic                        err,
  output logic                        hold_ovf,
  output logic [$clog2(HOLD_DEPTH):0] hold_count
`ifdef ROUTER_REG_ERRCNT_EN
  ,
  output logic [15:0]                 err_count
`endif
);

  localparam int CW = $clog2(HOLD_DEPTH) + 1;

  logic [DATA_W-1:0] r_header;
  logic [DATA_W-1:0] r_chk;
  logic [DATA_W-1:0] r_chk_byte;
  logic              r_chk_vld;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_vld;
  logic              r_parity_done;
  logic              r_low_pkt_valid;
  logic              r_err;
  logic              r_hold_ovf;

  logic              w_accept;
  logic              w_direct;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr_ok;
  logic              w_capture;
  logic              w_chk_have;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_count_nxt;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_chk_hdr;
  logic [DATA_W-1:0] w_chk_nxt;
  dout_src_e         w_src;

  assign w_accept   = ld_state && !full_state;
  assign w_direct   = w_accept && !fifo_full && (w_count == '0);
  assign w_push     = w_accept && !w_direct;
  assign w_pop      = laf_state && !fifo_full && (w_count != '0);
  assign w_wr_ok    = w_push && !w_full;
  assign w_capture  = w_accept && !pkt_valid;
  assign w_chk_have = r_chk_vld || w_capture;
  assign w_count_nxt = detect_add ? '0 : (w_count + CW'(w_wr_ok) - CW'(w_pop));

  router_hold_fifo #(
    .DATA_W    (DATA_W),
    .HOLD_DEPTH(HOLD_DEPTH)
  ) u_hold (
    .clock  (clock),
    .reset  (reset),
    .i_flush(detect_add),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_dat  (data_in),
    .o_dat  (w_head),
    .o_count(w_count),
    .o_full (w_full)
  );

  always_comb begin
    w_src = SRC_HOLD;
    if (lfd_state)     w_src = SRC_HDR;
    else if (w_pop)    w_src = SRC_POP;
    else if (w_direct) w_src = SRC_DIN;
  end

  // Header folds before the data byte when both land in one cycle.
  always_comb begin
    w_chk_hdr = r_chk;
    if (lfd_state)
      w_chk_hdr = DATA_W'(chk_fold(FOLD_W'(r_chk), FOLD_W'(r_header), PAR_MODE));
    w_chk_nxt = w_chk_hdr;
    if (w_accept && pkt_valid)
      w_chk_nxt = DATA_W'(chk_fold(FOLD_W'(w_chk_hdr), FOLD_W'(data_in), PAR_MODE));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_header        <= '0;
      r_chk           <= '0;
      r_chk_byte      <= '0;
      r_chk_vld       <= 1'b0;
      r_dout          <= '0;
      r_dout_vld      <= 1'b0;
      r_parity_done   <= 1'b0;
      r_low_pkt_valid <= 1'b0;
      r_err           <= 1'b0;
      r_hold_ovf      <= 1'b0;
    end else begin
      r_dout_vld <= (w_src != SRC_HOLD);
      case (w_src)
        SRC_HDR: r_dout <= r_header;
        SRC_POP: r_dout <= w_head;
        SRC_DIN: r_dout <= data_in;
        default: r_dout <= r_dout;
      endcase

      if (detect_add && pkt_valid) r_header <= data_in;

      // A new address abandons whatever packet was in flight.
      if (detect_add) begin
        r_chk         <= '0;
        r_chk_byte    <= '0;
        r_chk_vld     <= 1'b0;
        r_parity_done <= 1'b0;
        r_hold_ovf    <= 1'b0;
      end else begin
        r_chk <= w_chk_nxt;
        if (w_capture) begin
          r_chk_byte <= data_in;
          r_chk_vld  <= 1'b1;
        end
        if (w_chk_have && (w_count_nxt == '0)) r_parity_done <= 1'b1;
        if (w_push && w_full) r_hold_ovf <= 1'b1;
      end

      if (w_capture)        r_low_pkt_valid <= 1'b1;
      else if (rst_int_reg) r_low_pkt_valid <= 1'b0;

      r_err <= r_parity_done && (r_chk != r_chk_byte);
    end
  end

  assign dout          = r_dout;
  assign dout_valid    = r_dout_vld;
  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err           = r_err;
  assign hold_ovf      = r_hold_ovf;
  assign hold_count    = w_count;

`ifdef ROUTER_REG_ERRCNT_EN
  logic        r_err_d;
  logic        r_ovf_d;
  logic [15:0] r_err_count;
  logic [1:0]  w_inc;
  logic [16:0] w_sum;

  assign w_inc = {1'b0, r_err & ~r_err_d} + {1'b0, r_hold_ovf & ~r_ovf_d};
  assign w_sum = {1'b0, r_err_count} + {15'd0, w_inc};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_d     <= 1'b0;
      r_ovf_d     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_d     <= r_err;
      r_ovf_d     <= r_hold_ovf;
      r_err_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_router_reg_gen.sv
// Directed bench: two instances (XOR and additive check) driven by shared stimulus.
module tb_router_reg_gen;

  localparam int DW = 8;
  localparam int HD = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic          laf_state, full_state, rst_int_reg;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout_m [2];
  logic          dv_m   [2];
  logic          pd_m   [2];
  logic          lpv_m  [2];
  logic          err_m  [2];
  logic          ovf_m  [2];
  logic [CW-1:0] hc_m   [2];
`ifdef ROUTER_REG_ERRCNT_EN
  logic [15:0]   ec_m   [2];
`endif

  int ntest = 0;
  int nfail = 0;

  always #5 clock = ~clock;

  router_reg_gen #(.DATA_W(DW), .HOLD_DEPTH(HD), .PAR_MODE(0)) u_dut0 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout_m[0]), .dout_valid(dv_m[0]),
    .parity_done(pd_m[0]), .low_pkt_valid(lpv_m[0]), .err(err_m[0]),
    .hold_ovf(ovf_m[0]), .hold_count(hc_m[0])
`ifdef ROUTER_REG_ERRCNT_EN
    , .err_count(ec_m[0])
`endif
  );

  router_reg_gen #(.DATA_W(DW), .HOLD_DEPTH(HD), .PAR_MODE(1)) u_dut1 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout_m[1]), .dout_valid(dv_m[1]),
    .parity_done(pd_m[1]), .low_pkt_valid(lpv_m[1]), .err(err_m[1]),
    .hold_ovf(ovf_m[1]), .hold_count(hc_m[1])
`ifdef ROUTER_REG_ERRCNT_EN
    , .err_count(ec_m[1])
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pkt_valid = 1'b0; fifo_full = 1'b0; detect_add = 1'b0; lfd_state = 1'b0;
    ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
    data_in = '0;
  endtask

  task automatic all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk8({tag, "_dout"}, dout_m[d], 8'h00);
      chk1({tag, "_dv"}, dv_m[d], 1'b0);
      chk1({tag, "_pd"}, pd_m[d], 1'b0);
      chk1({tag, "_lpv"}, lpv_m[d], 1'b0);
      chk1({tag, "_err"}, err_m[d], 1'b0);
      chk1({tag, "_ovf"}, ovf_m[d], 1'b0);
      chk8({tag, "_hc"}, {5'd0, hc_m[d]}, 8'd0);
    end
  endtask

  // Header, two payload bytes, check byte with fifo_full low; e0/e1 = expected err per mode.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] cb, input logic e0, input logic e1);
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr; tick();
    chk1("pkt_hdr_dv", dv_m[0], 1'b0);
    chk1("pkt_pd_cleared", pd_m[0], 1'b0);
    detect_add = 1'b0; pkt_valid = 1'b0; lfd_state = 1'b1; tick();
    chk8("pkt_dout_hdr", dout_m[0], hdr);
    chk1("pkt_dv_hdr", dv_m[0], 1'b1);
    lfd_state = 1'b0; ld_state = 1'b1; pkt_valid = 1'b1; data_in = p0; tick();
    chk8("pkt_dout_p0", dout_m[0], p0);
    data_in = p1; tick();
    chk8("pkt_dout_p1", dout_m[1], p1);
    pkt_valid = 1'b0; data_in = cb; tick();
    chk8("pkt_dout_cb", dout_m[0], cb);
    chk1("pkt_lpv_set", lpv_m[0], 1'b1);
    chk1("pkt_pd0", pd_m[0], 1'b1);
    chk1("pkt_pd1", pd_m[1], 1'b1);
    chk1("pkt_err_not_yet", err_m[1], 1'b0);
    ld_state = 1'b0; rst_int_reg = 1'b1; tick();
    chk1("pkt_dv_idle", dv_m[0], 1'b0);
    chk8("pkt_dout_hold", dout_m[0], cb);
    chk1("pkt_lpv_clr", lpv_m[0], 1'b0);
    chk1("pkt_err_xor", err_m[0], e0);
    chk1("pkt_err_sum", err_m[1], e1);
    rst_int_reg = 1'b0; tick();
    chk1("pkt_err_xor_hold", err_m[0], e0);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #2 reset = 1'b1;
    #2 all_zero("rst");
`ifdef ROUTER_REG_ERRCNT_EN
    chk16("rst_ec", ec_m[0], 16'd0);
`endif
    tick(); tick();
    reset = 1'b0;

    // XOR check 05^11^22=36, sum 05+11+22=38.
    send_pkt(8'h05, 8'h11, 8'h22, 8'h36, 1'b0, 1'b1);
    send_pkt(8'h05, 8'h11, 8'h22, 8'h38, 1'b1, 1'b0);

    // Bytes park while the FIFO is full, then drain in order.
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h05; tick();
    detect_add = 1'b0; pkt_valid = 1'b0; lfd_state = 1'b1; tick();
    lfd_state = 1'b0; fifo_full = 1'b1; ld_state = 1'b1; pkt_valid = 1'b1;
    data_in = 8'h11; tick();
    chk8("drn_hc1", {5'd0, hc_m[0]}, 8'd1);
    chk1("drn_dv_blocked", dv_m[0], 1'b0);
    data_in = 8'h22; tick();
    chk8("drn_hc2", {5'd0, hc_m[0]}, 8'd2);
    pkt_valid = 1'b0; data_in = 8'h36; tick();
    chk8("drn_hc3", {5'd0, hc_m[0]}, 8'd3);
    chk1("drn_pd_wait", pd_m[0], 1'b0);
    chk1("drn_lpv", lpv_m[0], 1'b1);
    ld_state = 1'b0; laf_state = 1'b1; fifo_full = 1'b0; tick();
    chk8("drn_dout11", dout_m[0], 8'h11);
    chk8("drn_hc_a", {5'd0, hc_m[0]}, 8'd2);
    chk1("drn_pd_a", pd_m[0], 1'b0);
    tick();
    chk8("drn_dout22", dout_m[0], 8'h22);
    chk8("drn_hc_b", {5'd0, hc_m[0]}, 8'd1);
    chk1("drn_pd_b", pd_m[0], 1'b0);
    tick();
    chk8("drn_dout36", dout_m[0], 8'h36);
    chk8("drn_hc_c", {5'd0, hc_m[0]}, 8'd0);
    chk1("drn_pd_c", pd_m[0], 1'b1);
    tick();
    chk1("drn_dv_empty", dv_m[0], 1'b0);
    chk1("drn_err_xor", err_m[0], 1'b0);
    chk1("drn_err_sum", err_m[1], 1'b1);
    laf_state = 1'b0;

    // Six pushes into a four-entry buffer: bytes 5 and 6 are dropped.
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0A; tick();
    detect_add = 1'b0; fifo_full = 1'b1; ld_state = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      data_in = 8'(i); tick();
      chk8("ovf_hc", {5'd0, hc_m[0]}, (i > 4) ? 8'd4 : 8'(i));
      chk1("ovf_flag", ovf_m[0], (i >= 5));
    end
    ld_state = 1'b0; pkt_valid = 1'b0; laf_state = 1'b1; fifo_full = 1'b0; tick();
    chk8("ovf_pop1", dout_m[0], 8'h01);
    chk8("ovf_hc_pop1", {5'd0, hc_m[0]}, 8'd3);
    tick();
    chk8("ovf_pop2", dout_m[0], 8'h02);
    chk1("ovf_sticky", ovf_m[0], 1'b1);
`ifdef ROUTER_REG_ERRCNT_EN
    chk16("ovf_ec_xor", ec_m[0], 16'd2);
    chk16("ovf_ec_sum", ec_m[1], 16'd3);
`endif
    laf_state = 1'b0; detect_add = 1'b1; tick();
    chk8("flush_hc", {5'd0, hc_m[0]}, 8'd0);
    chk1("flush_ovf", ovf_m[0], 1'b0);

    // Asynchronous reset mid-packet with two bytes parked.
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h07; tick();
    detect_add = 1'b0; fifo_full = 1'b1; ld_state = 1'b1;
    data_in = 8'hA1; tick();
    data_in = 8'hA2; tick();
    chk8("pre_rst_hc", {5'd0, hc_m[0]}, 8'd2);
    chk1("pre_rst_lpv", lpv_m[0], 1'b1);
    idle();
    #2 reset = 1'b1;
    #1 all_zero("async_rst");
`ifdef ROUTER_REG_ERRCNT_EN
    chk16("async_rst_ec", ec_m[1], 16'd0);
`endif
    #1 reset = 1'b0;

    send_pkt(8'h05, 8'h11, 8'h22, 8'h37, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
